// File: rtl/seven_seg_scanner_if.sv
// Display-update handshake between a host and seven_seg_scanner.
// The host asserts load for one cycle with new digit data; the scanner acks when that data commits.
interface seven_seg_scanner_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load_ack;

  modport master (output load, output value, output dp_in, output blank_in, input load_ack);
  modport slave  (input load, input value, input dp_in, input blank_in, output load_ack);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Loads are held pending and commit only at a frame boundary, so no frame mixes old and new digits.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scanner_if.slave   bus,
  output logic [1:0]           sel,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic [15:0]   sh_val_q, sh_val_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    sh_blank_q, sh_blank_d;
  logic          ack_q, ack_d;
  logic          ftick_q, ftick_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic tick_c;
  logic boundary_c;
  logic [3:0] nibble_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick_c     = (presc_q == PW'(REFRESH_DIV - 1));
  assign boundary_c = tick_c && (sel_q == 2'd3);
  assign nibble_c   = sh_val_q[{sel_q, 2'b00} +: 4];

  // Next-state: prescaler/scan, pending capture, frame-boundary commit, output decode
  always_comb begin
    presc_d      = presc_q + PW'(1);
    sel_d        = sel_q;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    sh_val_d     = sh_val_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    ack_d        = 1'b0;
    ftick_d      = boundary_c;
    an_d         = ~(4'b0001 << sel_q);
    seg_d        = hex_to_seg(nibble_c);
    dp_d         = ~sh_dp_q[sel_q];

    if (tick_c) begin
      presc_d = '0;
      sel_d   = sel_q + 2'd1;
    end

    if (bus.load) begin
      pend_d       = 1'b1;
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank_in;
    end

    // A load landing on the boundary bypasses the pending registers
    if (boundary_c && (pend_q || bus.load)) begin
      pend_d     = 1'b0;
      ack_d      = 1'b1;
      sh_val_d   = bus.load ? bus.value    : pend_val_q;
      sh_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
      sh_blank_d = bus.load ? bus.blank_in : pend_blank_q;
    end

    if (sh_blank_q[sel_q]) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      sel_q        <= 2'd0;
      pend_q       <= 1'b0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      pend_blank_q <= 4'b0000;
      sh_val_q     <= 16'h0000;
      sh_dp_q      <= 4'b0000;
      sh_blank_q   <= 4'b1111;
      ack_q        <= 1'b0;
      ftick_q      <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      ack_q        <= ack_d;
      ftick_q      <= ftick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.load_ack = ack_q;
  assign sel          = sel_q;
  assign an           = an_q;
  assign seg          = seg_q;
  assign dp           = dp_q;
  assign frame_tick   = ftick_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Generates the rotating 2-bit digit select that feeds anode_decoder.
- Also produces active-low anode, segment and decimal-point drive directly.
- Display updates use a load/ack handshake. New values commit only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (legal range >= 2). The prescaler is clog2(REFRESH_DIV) bits wide.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  one-cycle request to display value/dp_in/blank_in
- value  input  16  four hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  input  4  per-digit decimal point, 1 = lit
- blank_in  input  4  per-digit blank, 1 = digit dark
- load_ack  output  1  one-cycle pulse when a pending load commits to the display
- sel  output  2  current digit index, drives anode_decoder.in
- an  output  4  active-low anodes, an[i] for digit i
- seg  output  7  active-low segments {g,f,e,d,c,b,a}
- dp  output  1  active-low decimal point
- frame_tick  output  1  one-cycle pulse marking end of digit 3 (frame boundary)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - prescaler=0, sel=0, pending flag=0, pending and shadow value/dp=0, shadow blank=4'b1111.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, load_ack=0, frame_tick=0.
  - Reset asserted mid-frame or mid-handshake discards pending data with no ack.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler==REFRESH_DIV-1).
  - On tick, sel <= sel+1 mod 4 (3 wraps to 0).
- Frame boundary: tick while sel==3. frame_tick is registered and asserts on the cycle after the boundary edge, i.e. together with sel==0.
- Load capture:
  - load=1 copies value/dp_in/blank_in into pending registers and sets pending flag.
  - A second load before commit overwrites the first. Latest wins; only one ack is issued.
- Commit:
  - At a frame boundary with pending flag set (or load=1 in that same cycle), the shadow registers take the pending data.
  - If load coincides with the boundary, the incoming inputs commit directly.
  - Pending flag clears, and load_ack pulses for 1 cycle, aligned with frame_tick.
  - Worst-case load-to-ack latency: 4*REFRESH_DIV cycles.
- Output stage (registered, 1-cycle latency from sel, i.e. an/seg/dp reflect the previous cycle's sel):
  - an = ~(1<<sel); forced to 4'b1111 if shadow blank[sel]=1.
  - seg = hexdecode(shadow nibble[sel]); forced to 7'h7F if blanked.
  - dp = ~shadow dp[sel]; forced to 1 if blanked.
- Hex decode table (active-low, {g..a}):
  - Digits 0-7: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
  - Digits 8-F: 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
- Exactly one or zero anodes are low in any cycle. An X-free reset is required.

Test Plan (REFRESH_DIV=4, frame = 16 cycles):
- Reset release, no load -> sel walks 0,0,0,0,1,1,1,1,2,... with wrap 3->0; an stays 4'b1111 and seg stays 7'h7F for the whole run; frame_tick pulses every 16 cycles.
- Load value=16'h1234, dp_in=0, blank_in=0 at cycle 2 -> load_ack and frame_tick both pulse at cycle 16. The frame that follows shows:
  - sel=0: an=1110, seg=0011001 ("4")
  - sel=1: an=1101, seg=0110000 ("3")
  - sel=2: an=1011, seg=0100100 ("2")
  - sel=3: an=0111, seg=1111001 ("1")
- Load 16'hABCD, then 16'hEF01 three cycles later, both in the same frame -> a single load_ack. The next frame shows EF01; ABCD never appears.
- Load asserted exactly in the boundary cycle -> that data commits immediately, load_ack pulses on the same edge, and the new digits appear from sel=0.
- Load 16'h8888, dp_in=4'b0101, blank_in=4'b0010 -> digit 1 dark (an=1111, seg=7F, dp=1); digits 0 and 2 show dp=0; digit 3 shows dp=1. All lit digits show seg=0000000.
- rst_n pulsed low mid-frame while a load is pending -> outputs drop to their reset values asynchronously; after release there is no load_ack and the display stays blank.
